adder_tree_operand_loader: RTL and testbench
============================================

Name: adder_tree_operand_loader

Overview:
- Upstream feeder for the 3-level, 8-input adder tree.
- Accepts a serial stream of ADDER_WIDTH-bit operands over a valid/ready handshake and gathers them into groups of NUM_OPERANDS.
- Presents each group as a parallel, registered operand bank with out_valid/out_ready, which drives the tree's input registers.
- A short group (early in_last) is zero-padded so the tree sum stays correct.

Parameters:
- ADDER_WIDTH, 22, width of each operand.
- NUM_OPERANDS, 8, operands per group. Must be a power of two, with 8 matching a 3-level tree.
- CNT_W, $clog2(NUM_OPERANDS)+1, width of out_count.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  ADDER_WIDTH  operand word.
- in_valid  in  1  in_data is valid.
- in_last  in  1  the current word closes its group early; qualified by in_valid.
- in_ready  out  1  loader can accept a word this cycle.
- out_ops  out  NUM_OPERANDS*ADDER_WIDTH  slot k at bits [k*ADDER_WIDTH +: ADDER_WIDTH]; slot index = tree leaf index (slot 0 = isum0_0_0_0, slot 7 = isum0_1_1_1).
- out_count  out  CNT_W  number of real operands in the group, 1..NUM_OPERANDS.
- out_last  out  1  group was closed by in_last.
- out_valid  out  1  out_ops/out_count/out_last are valid.
- out_ready  in  1  consumer takes the group this cycle.

Behaviour:
- Reset, taking effect on the clock edge where reset=1:
  - out_valid=0, out_ops=0, out_count=0, out_last=0.
  - Fill index=0, state=FILL.
  - in_ready=0 while reset is high; in_ready=1 in the first cycle after reset drops.
  - Reset mid-operation discards both any partial group and any presented group. Nothing is emitted.
- Accept: acc = in_valid && in_ready. On acc, in_data is written to fill slot idx.
- Completion: the group completes on acc when idx==NUM_OPERANDS-1 or in_last=1.
  - idx returns to 0.
  - The count recorded for the group is idx+1.
- States:
  - FILL: in_ready=1.
  - HOLD: in_ready=0; a completed group is waiting for the output register.
- Output register is free when !out_valid || out_ready.
- On the completing edge with the output register free:
  - The group, including the completing word, loads directly into out_ops.
  - out_valid=1 in the next cycle (latency 1 from the last accept).
  - State stays FILL.
- On the completing edge with the output register occupied and !out_ready:
  - State goes to HOLD.
  - On the first edge with out_ready=1, the held group transfers, out_valid stays 1, and state returns to FILL.
  - Group order is always preserved.
- Handshake on the output side:
  - out_ready with !out_valid is a no-op.
  - out_ops/out_count/out_last are stable while out_valid && !out_ready.
  - out_valid drops the cycle after a take unless a new group loads on the same edge. Back-to-back groups are allowed.
- Padding: slots with index >= out_count are 0 in out_ops. No stale data from earlier groups is allowed.
- in_last on the NUM_OPERANDS-th word: treated as a normal full group, with out_last=1 and out_count=NUM_OPERANDS.
- in_last and in_data are ignored when !acc.
- Throughput: with out_ready tied high, one full group per NUM_OPERANDS cycles, no bubbles. in_ready is low only in HOLD.
- Width: operands pass unmodified with no sign extension; the tree supplies the growth bits.

Decomposition:
- Package adder_tree_pkg holds:
  - ADDER_WIDTH and NUM_OPERANDS defaults, and TREE_LEVELS=3.
  - State enum {FILL, HOLD}.
  - Helper function for the slot bit offset.
- No sub-module; the fill bank, index counter and output register live in one module of about 150-250 lines.

Test Plan:
- Full group, out_ready=1: send 1..8 on consecutive cycles -> out_valid the cycle after word 8; out_ops slots 0..7 = 1..8; out_count=8; out_last=0; in_ready never drops.
- Short group: send 5, 6, 7 with in_last on 7 -> out_ops = {7,6,5} in slots 0..2 and slots 3..7 = 0; out_count=3; out_last=1. A following group of 0x3FFFFF x8 shows no leftover values.
- Backpressure: out_ready=0, send 16 words -> group A is presented and group B completes into HOLD; in_ready=0 after word 16. Raise out_ready -> A is taken, B is presented next cycle, in_ready returns to 1.
- Stall stability: hold out_ready=0 for 10 cycles with out_valid=1 -> out_ops/out_count/out_last unchanged every cycle.
- Reset mid-group: 4 words accepted, then reset for 1 cycle -> out_valid=0. The next 8 words (0x000001..0x000008) produce exactly one group with out_count=8 and no old data.
- Max value end-to-end with the tree: 8 x 0x3FFFFF -> tree sum0 = 0x1FFFFF8. Random valid/ready gaps over 1000 groups match the scoreboard.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// Shared constants, FSM state type and slot addressing for the adder-tree
// operand loader.
package adder_tree_pkg;

  localparam int DEF_ADDER_WIDTH  = 22;
  localparam int DEF_NUM_OPERANDS = 8;
  localparam int TREE_LEVELS      = 3;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Low bit of operand slot k in the flattened operand bank.
  function automatic int slot_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/adder_tree_operand_loader.sv
// Gathers a serial operand stream into zero-padded groups of NUM_OPERANDS and
// presents each group as a registered parallel bank for the adder tree.
// One completed group can wait in the fill bank (HOLD) while the output
// register is occupied, so a full group of slack exists between the stream
// and the tree.
module adder_tree_operand_loader
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH  = DEF_ADDER_WIDTH,
  parameter int NUM_OPERANDS = DEF_NUM_OPERANDS,
  parameter int CNT_W        = $clog2(NUM_OPERANDS) + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ADDER_WIDTH-1:0]              in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic [NUM_OPERANDS*ADDER_WIDTH-1:0] out_ops,
  output logic [CNT_W-1:0]                    out_count,
  output logic                                out_last,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int IDX_W = $clog2(NUM_OPERANDS);

  typedef logic [NUM_OPERANDS-1:0][ADDER_WIDTH-1:0] bank_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  bank_t            fill_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             hold_last_q;

  bank_t            out_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_last_q;
  logic             out_valid_q;

  logic             acc;
  logic             done;
  logic             out_free;
  bank_t            grp_d;
  logic [CNT_W-1:0] grp_cnt_d;

  // Input side is open in FILL only; reset forces it shut immediately.
  assign in_ready  = !reset && (state_q == FILL);
  assign acc       = in_valid && in_ready;
  assign done      = acc && ((idx_q == IDX_W'(NUM_OPERANDS - 1)) || in_last);
  assign out_free  = !out_valid_q || out_ready;
  assign grp_cnt_d = CNT_W'(idx_q) + CNT_W'(1);

  // Completed group as it will be presented: filled slots, the completing
  // word, and zeros above it so stale words from older groups never leak.
  always_comb begin
    grp_d = '0;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      if (k < int'(idx_q))       grp_d[k] = fill_q[k];
      else if (k == int'(idx_q)) grp_d[k] = in_data;
    end
  end

  // Fill/hold FSM together with the index counter and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      idx_q       <= '0;
      hold_cnt_q  <= '0;
      hold_last_q <= 1'b0;
      out_q       <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (acc) idx_q <= done ? '0 : idx_q + IDX_W'(1);

      case (state_q)
        FILL: begin
          if (done && out_free) begin
            out_q       <= grp_d;
            out_cnt_q   <= grp_cnt_d;
            out_last_q  <= in_last;
            out_valid_q <= 1'b1;
          end else if (done) begin
            // Output busy: park the finished group in the fill bank.
            fill_q      <= grp_d;
            hold_cnt_q  <= grp_cnt_d;
            hold_last_q <= in_last;
            state_q     <= HOLD;
          end else begin
            if (acc) fill_q[idx_q] <= in_data;
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          // out_valid is necessarily high here; a take refills it at once.
          if (out_ready) begin
            out_q      <= fill_q;
            out_cnt_q  <= hold_cnt_q;
            out_last_q <= hold_last_q;
            state_q    <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_slot
    assign out_ops[slot_lo(k, ADDER_WIDTH) +: ADDER_WIDTH] = out_q[k];
  end

  assign out_count = out_cnt_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// Bench for adder_tree_operand_loader: a queue-based group model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_adder_tree_operand_loader;

  localparam int W  = 22;
  localparam int N  = 8;
  localparam int CW = $clog2(N) + 1;
  localparam int OW = N * W;

  typedef struct {
    logic [OW-1:0] ops;
    int            cnt;
    bit            last;
  } grp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_ops;
  logic [CW-1:0] out_count;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  int  n_chk = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;
  int  rdy_mode = 1;   // 0: low, 1: high, 2: random
  bit  rnd_bit = 1'b1;

  grp_t         exp_q[$];
  logic [W-1:0] cur[$];

  adder_tree_operand_loader #(.ADDER_WIDTH(W), .NUM_OPERANDS(N)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_ops(out_ops), .out_count(out_count), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd_bit <= ($urandom_range(0, 3) != 0);
  end

  always_comb out_ready = (rdy_mode == 1) || (rdy_mode == 2 && rnd_bit);

  function automatic void chk(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  // Model: a group is pending from its completing accept until it is taken.
  // The output shows the oldest pending group; input closes with two pending.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_in_ready", OW'(in_ready), OW'(!reset && exp_q.size() < 2));
      chk("model_out_valid", OW'(out_valid), OW'(exp_q.size() > 0));
      if (out_valid && exp_q.size() > 0) begin
        chk("model_out_ops", out_ops, exp_q[0].ops);
        chk("model_out_count", OW'(out_count), OW'(exp_q[0].cnt));
        chk("model_out_last", OW'(out_last), OW'(exp_q[0].last));
      end
    end
    if (reset) begin
      exp_q.delete();
      cur.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        if (in_last || cur.size() == N) begin
          grp_t g;
          g.ops = '0;
          foreach (cur[i]) g.ops[i*W +: W] = cur[i];
          g.cnt  = cur.size();
          g.last = in_last;
          exp_q.push_back(g);
          cur.delete();
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic l);
    int n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck low after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    in_data  = W'($urandom);
  endtask

  function automatic logic [31:0] tree_sum(input logic [OW-1:0] ops);
    logic [31:0] s = 0;
    for (int k = 0; k < N; k++) s += 32'(ops[k*W +: W]);
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] snap_ops;
    logic [CW-1:0] snap_cnt;
    logic          snap_last;
    int            n;

    // Reset
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_low", OW'(in_ready), OW'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", OW'(out_valid), OW'(0));
    chk("rst_out_ops", out_ops, OW'(0));
    chk("rst_out_count", OW'(out_count), OW'(0));
    chk("rst_out_last", OW'(out_last), OW'(0));
    chk("rst_in_ready_high", OW'(in_ready), OW'(1));
    @(posedge clk); #1;

    // Full group 1..8 with out_ready high
    for (int i = 1; i <= N; i++) send(W'(i), 1'b0);
    @(negedge clk);
    chk("full_valid", OW'(out_valid), OW'(1));
    chk("full_ops", out_ops, {22'd8, 22'd7, 22'd6, 22'd5, 22'd4, 22'd3, 22'd2, 22'd1});
    chk("full_count", OW'(out_count), OW'(8));
    chk("full_last", OW'(out_last), OW'(0));
    @(posedge clk); #1;

    // Short group 5,6,7 then a full group of max values
    send(22'd5, 1'b0);
    send(22'd6, 1'b0);
    send(22'd7, 1'b1);
    @(negedge clk);
    chk("short_ops", out_ops, {110'd0, 22'd7, 22'd6, 22'd5});
    chk("short_count", OW'(out_count), OW'(3));
    chk("short_last", OW'(out_last), OW'(1));
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) send(22'h3FFFFF, 1'b0);
    @(negedge clk);
    chk("max_tree_sum", OW'(tree_sum(out_ops)), OW'(32'h1FFFFF8));
    chk("max_count", OW'(out_count), OW'(8));
    @(posedge clk); #1;

    // Backpressure: two groups with the output stalled
    rdy_mode = 0;
    for (int i = 0; i < 2 * N; i++) send(W'(12'h100 + i), 1'b0);
    @(negedge clk);
    chk("bp_in_ready_low", OW'(in_ready), OW'(0));
    chk("bp_a_slot0", OW'(out_ops[W-1:0]), OW'(22'h100));
    snap_ops  = out_ops;
    snap_cnt  = out_count;
    snap_last = out_last;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_ops", out_ops, snap_ops);
      chk("stall_count", OW'(out_count), OW'(snap_cnt));
      chk("stall_last", OW'(out_last), OW'(snap_last));
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_b_valid", OW'(out_valid), OW'(1));
    chk("bp_b_slot0", OW'(out_ops[W-1:0]), OW'(22'h108));
    chk("bp_in_ready_back", OW'(in_ready), OW'(1));
    @(posedge clk); #1;

    // Reset with a partial group in flight
    for (int i = 0; i < 4; i++) send(W'(22'h2AAAA0 + i), 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", OW'(in_ready), OW'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", OW'(out_valid), OW'(0));
    chk("mid_rst_out_ops", out_ops, OW'(0));
    @(posedge clk); #1;
    for (int i = 1; i <= N; i++) send(W'(i), 1'b0);
    @(negedge clk);
    chk("post_rst_ops", out_ops, {22'd8, 22'd7, 22'd6, 22'd5, 22'd4, 22'd3, 22'd2, 22'd1});
    chk("post_rst_count", OW'(out_count), OW'(8));
    @(posedge clk); #1;

    // Random gaps on both sides, checked by the model
    rdy_mode = 2;
    for (int g = 0; g < 1000; g++) begin
      int len;
      len = $urandom_range(1, N);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
        #0;
        send(W'($urandom), (i == len - 1) && (len < N || $urandom_range(0, 1) == 1));
      end
    end
    rdy_mode = 1;
    n = 0;
    while ((exp_q.size() > 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", OW'(exp_q.size() > 0 || out_valid), OW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
